example_unit: RTL and testbench



---
 rtl/example_pkg.sv | 8 +
 rtl/sat_counter.sv | 34 +++
 rtl/example_unit.sv | 46 ++++
 tb/tb_example_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/example_pkg.sv
// rtl/example_pkg.sv - shared width and vector type for example_unit
package example_pkg;

  localparam int EXAMPLE_W = 3;

  typedef logic [EXAMPLE_W-1:0] example_vec_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit up counter that stops at all-ones
module sat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = '1;
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != MAX_VAL)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/example_unit.sv
// rtl/example_unit.sv - AND of a/b with a shift-history and a saturating
// count of cycles in which the AND was high
module example_unit
  import example_pkg::*;
#(
  parameter int W = EXAMPLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a,
  input  logic         b,
  output logic         c,
  output logic [W-1:0] s1,
  output logic [W-1:0] s2
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s1_d;

  assign c = a & b;

  // Newest sample enters at bit 0; the oldest falls off the top.
  always_comb begin
    s1_d = {s1_q[W-2:0], c};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  assign s1 = s1_q;

  sat_counter #(
    .W(W)
  ) u_sat_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (c),
    .count(s2)
  );

endmodule

// File: tb/tb_example_unit.sv
// tb/tb_example_unit.sv - randomized and directed self-check of example_unit
// at W=3 and W=4 against a sample-history model
module tb_example_unit;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       c3;
  logic [2:0] s1_3;
  logic [2:0] s2_3;
  logic       c4;
  logic [3:0] s1_4;
  logic [3:0] s2_4;

  int n_cmp  = 0;
  int n_fail = 0;

  example_unit #(.W(3)) dut3 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c3), .s1(s1_3), .s2(s2_3)
  );

  example_unit #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c4), .s1(s1_4), .s2(s2_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: list of c values sampled since the last reset edge plus a tally of ones.
  int hist[$];
  int ones;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      ones = 0;
      model_valid = 1'b1;
    end else begin
      hist.push_back(int'(a & b));
      if ((a & b) == 1'b1) ones++;
      if (hist.size() > 16) void'(hist.pop_front());
    end
  end

  function automatic logic [7:0] exp_s1(int w);
    logic [7:0] v = '0;
    for (int k = 0; k < w; k++) begin
      if (k < hist.size()) v[k] = hist[hist.size() - 1 - k][0];
    end
    return v;
  endfunction

  function automatic logic [7:0] exp_s2(int w);
    int mx = (1 << w) - 1;
    return (ones > mx) ? 8'(mx) : 8'(ones);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("c_w3",  {7'd0, c3},   {7'd0, a & b});
      chk("s1_w3", {5'd0, s1_3}, exp_s1(3));
      chk("s2_w3", {5'd0, s2_3}, exp_s2(3));
      chk("c_w4",  {7'd0, c4},   {7'd0, a & b});
      chk("s1_w4", {4'd0, s1_4}, exp_s1(4));
      chk("s2_w4", {4'd0, s2_4}, exp_s2(4));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a   = 1'b1;
    b   = 1'b1;
    tick();
    tick();
    chk("reset_c",     {7'd0, c3},   8'd1);
    chk("reset_s1",    {5'd0, s1_3}, 8'd0);
    chk("reset_s2",    {5'd0, s2_3}, 8'd0);
    chk("reset_s1_w4", {4'd0, s1_4}, 8'd0);
    chk("reset_s2_w4", {4'd0, s2_4}, 8'd0);

    rst = 1'b0;
    a = 1'b1; b = 1'b1;
    #1 chk("basic_c_now", {7'd0, c3}, 8'd1);
    tick();
    chk("basic1_s1", {5'd0, s1_3}, 8'b001);
    chk("basic1_s2", {5'd0, s2_3}, 8'd1);
    a = 1'b0;
    #1 chk("basic2_c", {7'd0, c3}, 8'd0);
    tick();
    chk("basic2_s1", {5'd0, s1_3}, 8'b010);
    chk("basic2_s2", {5'd0, s2_3}, 8'd1);
    a = 1'b1;
    tick();
    chk("basic3_s1", {5'd0, s1_3}, 8'b101);
    chk("basic3_s2", {5'd0, s2_3}, 8'd2);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e >= 3) chk("sat_s1", {5'd0, s1_3}, 8'b111);
      chk("sat_s2", {5'd0, s2_3}, (e >= 7) ? 8'd7 : 8'(e));
    end

    a = 1'b0; b = 1'b1;
    tick();
    #1 a = 1'b1;
    #1 chk("comb_rise", {7'd0, c3}, 8'd1);
    a = 1'b0;
    #1 chk("comb_fall", {7'd0, c3}, 8'd0);
    a = 1'b1;
    #1 chk("comb_rise2", {7'd0, c3}, 8'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    a = 1'b1; b = 1'b1;
    for (int e = 0; e < 5; e++) tick();
    chk("mid_pre_s1", {5'd0, s1_3}, 8'b111);
    chk("mid_pre_s2", {5'd0, s2_3}, 8'd5);
    rst = 1'b1;
    tick();
    chk("mid_rst_s1", {5'd0, s1_3}, 8'd0);
    chk("mid_rst_s2", {5'd0, s2_3}, 8'd0);
    rst = 1'b0;
    tick();
    chk("mid_rel_s1", {5'd0, s1_3}, 8'b001);
    chk("mid_rel_s2", {5'd0, s2_3}, 8'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 0; e < 16; e++) tick();
    chk("w4_s1", {4'd0, s1_4}, 8'hf);
    chk("w4_s2", {4'd0, s2_4}, 8'd15);
    tick();
    chk("w4_hold_s2", {4'd0, s2_4}, 8'd15);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) begin
        a = 1'b1; b = 1'b1;
      end else begin
        a = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
      end
      tick();
    end

    rst = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
